// File: rtl/stream_mux_nto1.sv
// rtl/stream_mux_nto1.sv - N-to-1 handshaked stream mux with select or round-robin grant and registered output
module stream_mux_nto1 #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8,
  parameter int MODE   = 0,
  localparam int SEL_W = (N_CH <= 2) ? 1 : $clog2(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [SEL_W-1:0]         sel,
  input  logic [N_CH-1:0]          in_valid,
  input  logic [N_CH*DATA_W-1:0]   in_data,
  output logic [N_CH-1:0]          in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  input  logic                     out_ready
);

  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_data;
  logic [SEL_W-1:0]    r_out_ch;
  logic [SEL_W-1:0]    r_rr_ptr;

  logic                w_load;
  logic                w_xfer;
  logic [N_CH-1:0]     w_sel_grant;
  logic [N_CH-1:0]     w_rr_grant;
  logic [N_CH-1:0]     w_grant;
  logic [SEL_W-1:0]    w_sel_idx;
  logic [SEL_W-1:0]    w_rr_idx;
  logic [SEL_W-1:0]    w_idx;
  logic [DATA_W-1:0]   w_data;

  // External select: an out-of-range sel matches no channel and grants nothing.
  always_comb begin
    w_sel_grant = '0;
    w_sel_idx   = sel;
    for (int k = 0; k < N_CH; k++) begin
      if (int'(sel) == k) w_sel_grant[k] = in_valid[k];
    end
  end

  // Round-robin: scan upward from the channel after the last winner.
  always_comb begin : rr_arb
    int   v_c;
    logic v_found;
    w_rr_grant = '0;
    w_rr_idx   = '0;
    v_found    = 1'b0;
    v_c        = 0;
    for (int i = 1; i <= N_CH; i++) begin
      v_c = (int'(r_rr_ptr) + i) % N_CH;
      if (!v_found && in_valid[v_c]) begin
        w_rr_grant[v_c] = 1'b1;
        w_rr_idx        = SEL_W'(v_c);
        v_found         = 1'b1;
      end
    end
  end

  assign w_grant  = (MODE == 1) ? w_rr_grant : w_sel_grant;
  assign w_idx    = (MODE == 1) ? w_rr_idx   : w_sel_idx;
  assign w_load   = !r_out_valid || out_ready;
  // Ready is forced low during reset so no handshake can complete while held in reset.
  assign in_ready = (rst_n && w_load) ? w_grant : '0;
  assign w_xfer   = |in_ready;
  assign w_data   = in_data[int'(w_idx)*DATA_W +: DATA_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_rr_ptr    <= SEL_W'(N_CH - 1);
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_data;
      r_out_ch    <= w_idx;
      r_rr_ptr    <= w_idx;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_stream_mux_nto1.sv
// tb/tb_stream_mux_nto1.sv - bench for stream_mux_nto1: vector table, directed corner sequences, random vs reference model
module tb_stream_mux_nto1;

  logic        clk = 1'b0;
  logic        rst_n;
  int          total = 0;
  int          bad = 0;

  // Index 0: MODE 0, N_CH 4.  Index 1: MODE 1, N_CH 4.
  logic [1:0]  sel  [2];
  logic [3:0]  iv   [2];
  logic [31:0] id   [2];
  logic        ordy [2];
  logic [3:0]  ir   [2];
  logic        ov   [2];
  logic [7:0]  od   [2];
  logic [1:0]  och  [2];

  logic [1:0]  sel2;
  logic [2:0]  iv2;
  logic [23:0] id2;
  logic        ordy2;
  logic [2:0]  ir2;
  logic        ov2;
  logic [7:0]  od2;
  logic [1:0]  och2;

  logic        m_ov  [2];
  logic [7:0]  m_od  [2];
  int          m_och [2];
  int          m_ptr [2];
  logic [3:0]  e_ir  [2];

  typedef struct {
    logic [1:0]  sel;
    logic [3:0]  iv;
    logic [31:0] id;
    logic [3:0]  ir;
    logic        ov;
    logic [7:0]  od;
    logic [1:0]  och;
  } vec_t;
  vec_t tbl [6];

  always #5 clk = ~clk;

  stream_mux_nto1 #(.N_CH(4), .DATA_W(8), .MODE(0)) u_m0 (
    .clk(clk), .rst_n(rst_n), .sel(sel[0]), .in_valid(iv[0]), .in_data(id[0]),
    .in_ready(ir[0]), .out_valid(ov[0]), .out_data(od[0]), .out_ch(och[0]), .out_ready(ordy[0]));

  stream_mux_nto1 #(.N_CH(4), .DATA_W(8), .MODE(1)) u_m1 (
    .clk(clk), .rst_n(rst_n), .sel(sel[1]), .in_valid(iv[1]), .in_data(id[1]),
    .in_ready(ir[1]), .out_valid(ov[1]), .out_data(od[1]), .out_ch(och[1]), .out_ready(ordy[1]));

  stream_mux_nto1 #(.N_CH(3), .DATA_W(8), .MODE(0)) u_n3 (
    .clk(clk), .rst_n(rst_n), .sel(sel2), .in_valid(iv2), .in_data(id2),
    .in_ready(ir2), .out_valid(ov2), .out_data(od2), .out_ch(och2), .out_ready(ordy2));

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference grant: MODE 0 is a plain select; MODE 1 picks the valid channel
  // with the smallest forward distance from the last winner.
  function automatic logic [3:0] exp_grant(int mode, int s, logic [3:0] v, int ptr);
    int best, best_d, d;
    if (mode == 0) return (s < 4 && v[s]) ? 4'(1 << s) : 4'b0;
    best = -1;
    best_d = 99;
    for (int c = 0; c < 4; c++) begin
      d = (c - ptr + 3) % 4;
      if (v[c] && d < best_d) begin best = c; best_d = d; end
    end
    return (best < 0) ? 4'b0 : 4'(1 << best);
  endfunction

  function automatic int oh_idx(logic [3:0] oh);
    for (int c = 0; c < 4; c++) if (oh[c]) return c;
    return 0;
  endfunction

  // Inputs are set at a falling edge; check ready, clock once, check the held beat.
  task automatic cyc(int p, string nm, logic [3:0] e_r, logic e_v, logic [7:0] e_d, logic [1:0] e_c);
    #1 chk({nm, ".ready"}, 32'(ir[p]), 32'(e_r));
    @(posedge clk);
    #1;
    chk({nm, ".valid"}, 32'(ov[p]), 32'(e_v));
    chk({nm, ".data"}, 32'(od[p]), 32'(e_d));
    chk({nm, ".ch"}, 32'(och[p]), 32'(e_c));
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    for (int p = 0; p < 2; p++) begin
      sel[p] = '0; iv[p] = '0; id[p] = '0; ordy[p] = 1'b1;
    end
    sel2 = '0; iv2 = '0; id2 = '0; ordy2 = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0] = '{2'd2, 4'b0100, 32'h00A50000, 4'b0100, 1'b1, 8'hA5, 2'd2};
    tbl[1] = '{2'd1, 4'b1000, 32'h77000000, 4'b0000, 1'b0, 8'hA5, 2'd2};
    tbl[2] = '{2'd0, 4'b1111, 32'h44332211, 4'b0001, 1'b1, 8'h11, 2'd0};
    tbl[3] = '{2'd3, 4'b1000, 32'h7E000000, 4'b1000, 1'b1, 8'h7E, 2'd3};
    tbl[4] = '{2'd3, 4'b0111, 32'h00BBCCDD, 4'b0000, 1'b0, 8'h7E, 2'd3};
    tbl[5] = '{2'd1, 4'b0010, 32'h0000C300, 4'b0010, 1'b1, 8'hC3, 2'd1};

    // Reset state, with every channel offering a beat.
    rst_n = 1'b0;
    clear_inputs();
    iv[0] = 4'b1111; iv[1] = 4'b1111; iv2 = 3'b111;
    repeat (2) @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      chk("rst.ready", 32'(ir[p]), 32'h0);
      chk("rst.valid", 32'(ov[p]), 32'h0);
      chk("rst.data", 32'(od[p]), 32'h0);
      chk("rst.ch", 32'(och[p]), 32'h0);
    end
    chk("rst.n3_ready", 32'(ir2), 32'h0);
    clear_inputs();
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      sel[0] = tbl[i].sel; iv[0] = tbl[i].iv; id[0] = tbl[i].id; ordy[0] = 1'b1;
      cyc(0, $sformatf("tbl%0d", i), tbl[i].ir, tbl[i].ov, tbl[i].od, tbl[i].och);
    end

    // Backpressure: held beat stays put and a sel change while stalled does not matter.
    sel[0] = 2'd0; iv[0] = 4'b0001; id[0] = 32'h0000005A; ordy[0] = 1'b1;
    cyc(0, "bp_load", 4'b0001, 1'b1, 8'h5A, 2'd0);
    sel[0] = 2'd1; iv[0] = 4'b0011; id[0] = 32'h0000665A; ordy[0] = 1'b0;
    repeat (5) cyc(0, "bp_stall", 4'b0000, 1'b1, 8'h5A, 2'd0);
    ordy[0] = 1'b1;
    cyc(0, "bp_drain_load", 4'b0010, 1'b1, 8'h66, 2'd1);

    // Three channels: sel=3 is out of range and never grants.
    sel2 = 2'd3; iv2 = 3'b111; id2 = 24'h332211; ordy2 = 1'b1;
    repeat (3) begin
      #1 chk("n3_oob.ready", 32'(ir2), 32'h0);
      @(posedge clk);
      #1 chk("n3_oob.valid", 32'(ov2), 32'h0);
      @(negedge clk);
    end
    sel2 = 2'd2;
    #1 chk("n3_sel2.ready", 32'(ir2), 32'b100);
    @(posedge clk);
    #1;
    chk("n3_sel2.valid", 32'(ov2), 32'h1);
    chk("n3_sel2.data", 32'(od2), 32'h33);
    chk("n3_sel2.ch", 32'(och2), 32'h2);
    @(negedge clk);

    // Round-robin with ch1, ch3 valid, then idle; the pointer must survive the idle cycles.
    iv[1] = 4'b1010; id[1] = 32'hD0C0B0A0; ordy[1] = 1'b1;
    cyc(1, "rr13_a", 4'b0010, 1'b1, 8'hB0, 2'd1);
    cyc(1, "rr13_b", 4'b1000, 1'b1, 8'hD0, 2'd3);
    cyc(1, "rr13_c", 4'b0010, 1'b1, 8'hB0, 2'd1);
    iv[1] = 4'b0000;
    repeat (3) cyc(1, "rr_idle", 4'b0000, 1'b0, 8'hB0, 2'd1);
    iv[1] = 4'b1111;
    cyc(1, "rr_resume", 4'b0100, 1'b1, 8'hC0, 2'd2);

    // Reset mid-stream, then full-rate rotation from channel 0.
    id[1] = 32'h44332211;
    cyc(1, "pre_rst", 4'b1000, 1'b1, 8'h44, 2'd3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst.valid", 32'(ov[1]), 32'h0);
    chk("mid_rst.ready", 32'(ir[1]), 32'h0);
    chk("mid_rst.data", 32'(od[1]), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(1, $sformatf("rr_full%0d", i), 4'(1 << (i % 4)), 1'b1,
          8'((i % 4 + 1) * 8'h11), 2'(i % 4));
    end

    // Random traffic on both 4-channel instances against the reference model.
    do_reset();
    for (int p = 0; p < 2; p++) begin
      m_ov[p] = 1'b0; m_od[p] = '0; m_och[p] = 0; m_ptr[p] = 3;
    end
    repeat (400) begin
      for (int p = 0; p < 2; p++) begin
        for (int k = 0; k < 4; k++) begin
          if (!iv[p][k]) begin
            iv[p][k] = 1'($urandom_range(0, 1));
            id[p][k*8 +: 8] = 8'($urandom);
          end
        end
        ordy[p] = ($urandom_range(0, 3) != 0);
        sel[p]  = 2'($urandom);
      end
      #1;
      for (int p = 0; p < 2; p++) begin
        e_ir[p] = (!m_ov[p] || ordy[p]) ? exp_grant(p, int'(sel[p]), iv[p], m_ptr[p]) : 4'b0;
        chk($sformatf("rnd%0d.ready", p), 32'(ir[p]), 32'(e_ir[p]));
      end
      @(posedge clk);
      #1;
      for (int p = 0; p < 2; p++) begin
        if (e_ir[p] != 4'b0) begin
          int c;
          c = oh_idx(e_ir[p]);
          m_ov[p]  = 1'b1;
          m_od[p]  = id[p][c*8 +: 8];
          m_och[p] = c;
          m_ptr[p] = c;
          iv[p][c] = 1'b0;
        end else if (ordy[p]) begin
          m_ov[p] = 1'b0;
        end
        chk($sformatf("rnd%0d.valid", p), 32'(ov[p]), 32'(m_ov[p]));
        chk($sformatf("rnd%0d.data", p), 32'(od[p]), 32'(m_od[p]));
        chk($sformatf("rnd%0d.ch", p), 32'(och[p]), 32'(m_och[p]));
      end
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
